// File: rtl/wav_recorder.sv
// wav_recorder: captures an 8-bit unsigned audio stream into a sample RAM at a
// prescaled rate. Recording starts on a start pulse, either at once or after a
// level trigger. It ends at a programmed last address or on a stop pulse.
module wav_recorder #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DIV    = 2177,
  parameter logic [7:0]  THRESH = 8'd16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              trig_en,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [7:0]        audio_in,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_d,
  output logic              busy,
  output logic              armed,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  // Prescaler must hold 0..DIV; keep at least one bit when DIV is 0.
  localparam int unsigned PW = (DIV < 1) ? 1 : $clog2(DIV + 1);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRecord
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              fin_q, fin_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [7:0]        d_q, d_d;
  logic              done_q, done_d;

  logic              tick;
  logic              trig_hit;
  logic              wr_fire;
  logic [7:0]        dev;

  // Distance of the incoming sample from the 128 midpoint (0..128).
  always_comb begin
    if (audio_in >= 8'd128) begin
      dev = audio_in - 8'd128;
    end else begin
      dev = 8'd128 - audio_in;
    end
  end

  assign tick     = (state_q != StIdle) && (presc_q == PW'(DIV));
  assign trig_hit = (dev > THRESH);

  // Next-state, prescaler, write-address and output-register logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    addr_d  = addr_q;
    last_d  = last_q;
    fin_d   = fin_q;
    count_d = count_q;
    we_d    = 1'b0;
    a_d     = a_q;
    d_d     = d_q;
    done_d  = 1'b0;
    wr_fire = 1'b0;

    case (state_q)
      StIdle: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          last_d  = last_addr;
          count_d = '0;
          addr_d  = '0;
          presc_d = '0;
          fin_d   = 1'b0;
          state_d = trig_en ? StArmed : StRecord;
        end
      end
      StArmed, StRecord: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (stop) begin
          // A write registered last cycle is already on the port; suppress any new one.
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (we_q && fin_q) begin
          // Final write is on the port this cycle.
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (tick && !fin_q) begin
          if (state_q == StRecord) begin
            wr_fire = 1'b1;
          end else if (trig_hit) begin
            // Trigger sample itself goes to address 0.
            wr_fire = 1'b1;
            state_d = StRecord;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (wr_fire) begin
      we_d    = 1'b1;
      a_d     = addr_q;
      d_d     = audio_in;
      count_d = count_q + 1'b1;
      // Address saturates at last_addr; no wrap.
      if (addr_q == last_q) begin
        fin_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      addr_q  <= '0;
      last_q  <= '0;
      fin_q   <= 1'b0;
      count_q <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
      count_q <= count_d;
      we_q    <= we_d;
      a_q     <= a_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  assign ram_we = we_q;
  assign ram_a  = a_q;
  assign ram_d  = d_q;
  assign busy   = (state_q != StIdle);
  assign armed  = (state_q == StArmed);
  assign done   = done_q;
  assign count  = count_q;

endmodule

// File: tb/tb_wav_recorder.sv
// Directed bench for wav_recorder: a DIV=3 instance for the main scenarios and
// an ADDR_W=4, DIV=1 instance for the full-address-range run.
module tb_wav_recorder;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       trig_en;
  logic [7:0] last_addr;
  logic [7:0] audio_in;
  logic       ram_we;
  logic [7:0] ram_a;
  logic [7:0] ram_d;
  logic       busy;
  logic       armed;
  logic       done;
  logic [8:0] count;

  logic       s_start;
  logic       s_stop;
  logic       s_trig;
  logic [3:0] s_last;
  logic       s_we;
  logic [3:0] s_a;
  logic [7:0] s_d;
  logic       s_busy;
  logic       s_armed;
  logic       s_done;
  logic [4:0] s_count;

  int checks = 0;
  int errors = 0;

  int          wr_cyc[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cyc;
  int          done_n;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_exp_t;

  typedef struct {
    logic [7:0] level;
    bit         fire;
  } trig_vec_t;

  wr_exp_t   imm_tab[4];
  trig_vec_t trig_tab[9];

  wav_recorder #(
    .ADDR_W(8),
    .DIV   (3),
    .THRESH(8'd16)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .trig_en  (trig_en),
    .last_addr(last_addr),
    .audio_in (audio_in),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .busy     (busy),
    .armed    (armed),
    .done     (done),
    .count    (count)
  );

  wav_recorder #(
    .ADDR_W(4),
    .DIV   (1),
    .THRESH(8'd16)
  ) u_small (
    .clk      (clk),
    .reset    (reset),
    .start    (s_start),
    .stop     (s_stop),
    .trig_en  (s_trig),
    .last_addr(s_last),
    .audio_in (audio_in),
    .ram_we   (s_we),
    .ram_a    (s_a),
    .ram_d    (s_d),
    .busy     (s_busy),
    .armed    (s_armed),
    .done     (s_done),
    .count    (s_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic trig, input logic [7:0] la);
    start     = 1'b1;
    trig_en   = trig;
    last_addr = la;
    step();
    start = 1'b0;
  endtask

  // Runs n cycles and logs writes relative to the call; optional ramp and stop.
  task automatic collect(input int n, input bit ramp, input int stop_at);
    wr_cyc.delete();
    wr_a.delete();
    wr_d.delete();
    done_cyc = -1;
    done_n   = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      stop = 1'b0;
      if (ram_we) begin
        wr_cyc.push_back(k);
        wr_a.push_back(32'(ram_a));
        wr_d.push_back(32'(ram_d));
        if (ramp) audio_in = audio_in + 8'd1;
        if (stop_at != 0 && wr_cyc.size() == stop_at) stop = 1'b1;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
  endtask

  initial begin
    imm_tab[0] = '{cyc: 4,  addr: 0, data: 10};
    imm_tab[1] = '{cyc: 8,  addr: 1, data: 11};
    imm_tab[2] = '{cyc: 12, addr: 2, data: 12};
    imm_tab[3] = '{cyc: 16, addr: 3, data: 13};

    trig_tab[0] = '{level: 8'd130, fire: 1'b0};
    trig_tab[1] = '{level: 8'd144, fire: 1'b0};
    trig_tab[2] = '{level: 8'd145, fire: 1'b1};
    trig_tab[3] = '{level: 8'd112, fire: 1'b0};
    trig_tab[4] = '{level: 8'd111, fire: 1'b1};
    trig_tab[5] = '{level: 8'd100, fire: 1'b1};
    trig_tab[6] = '{level: 8'd0,   fire: 1'b1};
    trig_tab[7] = '{level: 8'd255, fire: 1'b1};
    trig_tab[8] = '{level: 8'd128, fire: 1'b0};

    clk       = 1'b0;
    reset     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    trig_en   = 1'b0;
    last_addr = 8'd0;
    audio_in  = 8'd0;
    s_start   = 1'b0;
    s_stop    = 1'b0;
    s_trig    = 1'b0;
    s_last    = 4'd0;

    do_reset();
    check("rst_we",    32'(ram_we), 0);
    check("rst_a",     32'(ram_a),  0);
    check("rst_d",     32'(ram_d),  0);
    check("rst_busy",  32'(busy),   0);
    check("rst_armed", 32'(armed),  0);
    check("rst_done",  32'(done),   0);
    check("rst_count", 32'(count),  0);

    // Immediate mode, last_addr=3, ramp 10,11,12,13 advancing per write.
    audio_in = 8'd10;
    pulse_start(1'b0, 8'd3);
    check("imm_busy_s1", 32'(busy), 1);
    collect(24, 1'b1, 0);
    check("imm_nwr", 32'(wr_cyc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("imm_cyc",  (wr_cyc.size() > i) ? 32'(wr_cyc[i]) : 32'hffff_ffff,
            32'(imm_tab[i].cyc));
      check("imm_addr", (wr_a.size() > i) ? wr_a[i] : 32'hffff_ffff, 32'(imm_tab[i].addr));
      check("imm_data", (wr_d.size() > i) ? wr_d[i] : 32'hffff_ffff, 32'(imm_tab[i].data));
    end
    check("imm_done_cyc", 32'(done_cyc), 17);
    check("imm_done_n",   32'(done_n),   1);
    check("imm_count",    32'(count),    4);
    check("imm_busy_end", 32'(busy),     0);

    // Trigger level table: one tick window per level, strict greater-than.
    for (int t = 0; t < 9; t++) begin
      do_reset();
      audio_in = trig_tab[t].level;
      pulse_start(1'b1, 8'd10);
      check("trg_armed_s1", 32'(armed), 1);
      collect(4, 1'b0, 0);
      check("trg_fire", 32'(wr_cyc.size()), 32'(trig_tab[t].fire));
      if (trig_tab[t].fire) begin
        check("trg_addr",  (wr_a.size() > 0) ? wr_a[0] : 32'hffff_ffff, 0);
        check("trg_data",  (wr_d.size() > 0) ? wr_d[0] : 32'hffff_ffff,
              32'(trig_tab[t].level));
        check("trg_armed", 32'(armed), 0);
      end else begin
        check("trg_armed", 32'(armed), 1);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("trg_stop_done", 32'(done), 1);
      check("trg_stop_busy", 32'(busy), 0);
    end

    // Quiet for 5 ticks, then trigger on 100, then keep recording.
    do_reset();
    audio_in = 8'd130;
    pulse_start(1'b1, 8'd10);
    collect(20, 1'b0, 0);
    check("seq_quiet_nwr", 32'(wr_cyc.size()), 0);
    check("seq_quiet_armed", 32'(armed), 1);
    audio_in = 8'd100;
    collect(4, 1'b0, 0);
    check("seq_trig_nwr", 32'(wr_cyc.size()), 1);
    check("seq_trig_cyc", (wr_cyc.size() > 0) ? 32'(wr_cyc[0]) : 32'hffff_ffff, 4);
    check("seq_trig_addr", (wr_a.size() > 0) ? wr_a[0] : 32'hffff_ffff, 0);
    check("seq_trig_data", (wr_d.size() > 0) ? wr_d[0] : 32'hffff_ffff, 100);
    check("seq_trig_armed", 32'(armed), 0);
    audio_in = 8'd144;
    collect(4, 1'b0, 0);
    check("seq_rec_addr", (wr_a.size() > 0) ? wr_a[0] : 32'hffff_ffff, 1);
    check("seq_rec_data", (wr_d.size() > 0) ? wr_d[0] : 32'hffff_ffff, 144);

    // Stop right after the second write.
    do_reset();
    audio_in = 8'd50;
    pulse_start(1'b0, 8'd10);
    collect(20, 1'b0, 2);
    check("stop_nwr",      32'(wr_cyc.size()), 2);
    check("stop_done_cyc", 32'(done_cyc), 9);
    check("stop_done_n",   32'(done_n), 1);
    check("stop_count",    32'(count), 2);
    check("stop_busy",     32'(busy), 0);

    // start while busy must not restart the capture.
    do_reset();
    audio_in = 8'd40;
    pulse_start(1'b0, 8'd10);
    collect(5, 1'b0, 0);
    check("rst_busy_nwr0", 32'(wr_cyc.size()), 1);
    pulse_start(1'b0, 8'd2);
    collect(8, 1'b0, 0);
    check("busy_start_nwr", 32'(wr_cyc.size()), 2);
    check("busy_start_cyc", (wr_cyc.size() > 0) ? 32'(wr_cyc[0]) : 32'hffff_ffff, 2);
    check("busy_start_a0", (wr_a.size() > 0) ? wr_a[0] : 32'hffff_ffff, 1);
    check("busy_start_a1", (wr_a.size() > 1) ? wr_a[1] : 32'hffff_ffff, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // start and stop together in IDLE: nothing happens.
    do_reset();
    start   = 1'b1;
    stop    = 1'b1;
    trig_en = 1'b0;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 32'(busy), 0);
    collect(10, 1'b0, 0);
    check("ss_nwr",  32'(wr_cyc.size()), 0);
    check("ss_done", 32'(done_n), 0);

    // Full 4-bit address range with DIV=1: 16 writes, no wrap.
    begin
      int nw;
      int bad;
      int dcyc;
      nw   = 0;
      bad  = 0;
      dcyc = -1;
      do_reset();
      s_start = 1'b1;
      s_last  = 4'd15;
      step();
      s_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (s_we) begin
          if (s_a != 4'(nw)) bad++;
          if (k != 2 * (nw + 1)) bad++;
          nw++;
        end
        if (s_done && dcyc < 0) dcyc = k;
      end
      check("small_nwr",  32'(nw),      16);
      check("small_bad",  32'(bad),     0);
      check("small_done", 32'(dcyc),    33);
      check("small_cnt",  32'(s_count), 16);
      check("small_a",    32'(s_a),     15);
      check("small_busy", 32'(s_busy),  0);
    end

    // Reset between ticks mid-record, then a fresh capture from address 0.
    do_reset();
    audio_in = 8'd77;
    pulse_start(1'b0, 8'd10);
    collect(10, 1'b0, 0);
    check("mr_pre_nwr", 32'(wr_cyc.size()), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_we",    32'(ram_we), 0);
    check("mr_a",     32'(ram_a),  0);
    check("mr_d",     32'(ram_d),  0);
    check("mr_busy",  32'(busy),   0);
    check("mr_armed", 32'(armed),  0);
    check("mr_done",  32'(done),   0);
    check("mr_count", 32'(count),  0);
    collect(8, 1'b0, 0);
    check("mr_quiet_nwr", 32'(wr_cyc.size()), 0);
    pulse_start(1'b0, 8'd10);
    collect(4, 1'b0, 0);
    check("mr_re_nwr",  32'(wr_cyc.size()), 1);
    check("mr_re_addr", (wr_a.size() > 0) ? wr_a[0] : 32'hffff_ffff, 0);
    check("mr_re_data", (wr_d.size() > 0) ? wr_d[0] : 32'hffff_ffff, 77);
    check("mr_re_cnt",  32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wav_recorder.md
# wav_recorder

Captures an 8-bit unsigned audio stream into a sample RAM at a fixed prescaled rate, producing the write-port traffic that the sample-playback path later reads back. It sits between an audio source (live mix or test tone) and port A of the sample `dpram`. Recording starts on a `start` pulse, either immediately or after a level trigger. It stops at a programmed last address or on a `stop` pulse.

## Interface
Parameters:
- `ADDR_W`, 14, RAM address width; one sample per address.
- `DIV`, 2177, prescaler terminal count; one sample every `DIV+1` clocks (≈11 kHz at 24 MHz).
- `THRESH`, 8'd16, trigger threshold, as distance from midpoint 128.

Ports:
- `clk`, in, 1, system clock (`clk_sys` domain).
- `reset`, in, 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`, in, 1, single-cycle request to begin a capture.
- `stop`, in, 1, single-cycle abort.
- `trig_en`, in, 1, sampled on `start`: 1 = wait for level trigger, 0 = record immediately.
- `last_addr`, in, ADDR_W, final address written; sampled on `start`.
- `audio_in`, in, 8, unsigned sample, midpoint 128.
- `ram_we`, out, 1, RAM write strobe, one cycle per sample.
- `ram_a`, out, ADDR_W, RAM write address.
- `ram_d`, out, 8, RAM write data.
- `busy`, out, 1, high in ARMED or RECORD.
- `armed`, out, 1, high in ARMED only.
- `done`, out, 1, one-cycle pulse when a capture ends (completion or abort).
- `count`, out, ADDR_W+1, samples written by the current or most recent capture.

## Operation
- States: IDLE, ARMED, RECORD.
- IDLE:
  - `start` latches `last_addr` and `trig_en`, clears `count`, write address and prescaler.
  - Next state is ARMED if `trig_en`=1, else RECORD.
- Prescaler:
  - Runs only in ARMED/RECORD and counts 0..DIV.
  - A "tick" is any cycle where prescaler==DIV; prescaler then returns to 0.
- ARMED:
  - On each tick, compute `dev` = |audio_in − 128|, 8-bit, no overflow (0..128).
  - If `dev` > THRESH, go to RECORD. That same tick's sample is also written to address 0, so the trigger sample is never lost.
  - Otherwise nothing is written.
- RECORD:
  - On each tick, register `audio_in` and the current address.
  - Next cycle: `ram_we`=1, `ram_a`=address, `ram_d`=sample; address and `count` increment.
- Completion: the write with `ram_a`==latched `last_addr` is the final one.
  - In the cycle after that write: state→IDLE, `done`=1.
  - `count` = last_addr+1; with all ones this is 2^ADDR_W, which is why `count` is ADDR_W+1 bits.
- `stop` in ARMED or RECORD:
  - State→IDLE next cycle with `done`=1.
  - A write already registered for that cycle still completes; no further writes follow.
  - `count` holds the number written.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and nothing happens.
- `start` while busy is ignored; `stop` in IDLE is ignored (no `done`).
- Address never wraps; the write address stops at `last_addr`.

## Timing
- Reset values: state IDLE; `ram_we`, `busy`, `armed`, `done` = 0; `ram_a`, `ram_d`, `count`, prescaler = 0.
- `start` at cycle S: `busy`=1 from S+1. The first tick is at S+1+DIV, and the first `ram_we` (immediate mode) is at S+2+DIV.
- Write spacing is exactly DIV+1 cycles. `ram_we` is never high on consecutive cycles when DIV≥1.
- `ram_a`/`ram_d` are valid whenever `ram_we`=1 and hold their last value otherwise.
- `done` rises the cycle after the final write, together with `busy` falling.
- `reset` mid-capture: next cycle all outputs are at reset values. No write is issued on or after the reset cycle.

## Test plan
- Immediate mode with DIV=3, last_addr=3, ramp input 10,11,12…:
  - Expect 4 writes, 4 cycles apart, to addr 0..3.
  - Data equals the input sampled at each tick.
  - `done` one cycle after the 4th write; `count`=4.
- Trigger mode with THRESH=16:
  - Input 130 for 5 ticks: no writes, `armed`=1.
  - Then input 100 (dev 28): first write addr 0, data 100, `armed`=0.
  - Input 144 (dev 16): no trigger, because the comparison is strictly greater.
- `stop` after the 2nd write (last_addr=10):
  - Writes stop, `done`=1 next cycle, `count`=2, `busy`=0.
- `start` while busy: no restart; address continues incrementing. `start`+`stop` together in IDLE: stays IDLE, no `done`.
- ADDR_W=4, last_addr=15, DIV=1:
  - 16 writes to addr 0..15, no wrap to 0, `count`=16.
- `reset` asserted between ticks mid-RECORD:
  - All outputs 0 next cycle.
  - A subsequent `start` records from addr 0 again.
